lfsr_prng: RTL

//  Parametrised Fibonacci LFSR pseudo-random source, the generalised successor to the fixed 8-bit LFSR.
//  It has configurable width, tap mask, seed and bits-per-advance, a runtime seed load and a
//  one-entry valid/ready output register. A period-wrap pulse and an advance counter support

---
 rtl/lfsr_prng.sv | 82 ++++++++
 1 files changed

// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR with runtime seed load, one-entry valid/ready output
// register, period-wrap pulse and an advance counter relative to the last anchor.
module lfsr_prng #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 'h1D,
  parameter logic [WIDTH-1:0] SEED  = 'd1,
  parameter int              STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] lfsr,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [WIDTH-1:0] rnd_data,
  output logic             wrap,
  output logic [WIDTH-1:0] step_cnt
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] anchor;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] seed_val;
  logic             adv;

  // A zero state would lock the register up, so it re-enters the sequence at SEED.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    if (s == '0) begin
      t = SEED;
    end else begin
      for (int i = 0; i < STEPS; i++) begin
        t = {^(t & TAPS), t[WIDTH-1:1]};
      end
    end
    return t;
  endfunction

  always_comb begin
    nxt      = advance(state);
    seed_val = (load_data == '0) ? SEED : load_data;
    adv      = en & (~rnd_valid | rnd_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SEED;
      anchor    <= SEED;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      wrap      <= 1'b0;
      step_cnt  <= '0;
    end else if (load) begin
      state     <= seed_val;
      anchor    <= seed_val;
      rnd_valid <= 1'b0;
      wrap      <= 1'b0;
      step_cnt  <= '0;
    end else begin
      wrap <= 1'b0;
      if (adv) begin
        state     <= nxt;
        rnd_data  <= nxt;
        rnd_valid <= 1'b1;
        if (nxt == anchor) begin
          wrap     <= 1'b1;
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end else if (rnd_valid && rnd_ready) begin
        rnd_valid <= 1'b0;
      end
    end
  end

  assign lfsr = state;

endmodule
